sobel_grad: RTL and testbench
=============================

# sobel_grad

Streaming 3x3 Sobel gradient-magnitude stage directly upstream of the gradient normaliser in the DisparityMap path. It consumes one 8-bit grey pixel per enabled cycle in raster order and buffers two image lines internally. For every accepted pixel it emits one 12-bit L1 gradient |Gx|+|Gy| on `cost_grad`, which is the normaliser's input. It shares the same `clken` stall semantics so both stages can be chained without extra glue.

## Interface
- `IMG_W`, 640, pixels per line (≥3); sets line-buffer depth and column-counter wrap
- `IMG_H`, 480, lines per frame (≥3); sets row-counter wrap
- `clk`  input  1  clock; all state updates on rising edge
- `rst`  input  1  synchronous, active-low reset
- `clken`  input  1  global pipeline enable; low = every register (counters, line buffers, window, pipeline, outputs) holds
- `pix_in`  input  8  unsigned grey pixel
- `pix_valid`  input  1  `pix_in` is a real pixel this cycle; accepted only when `clken & pix_valid`
- `pix_sof`  input  1  qualifies an accepted pixel as frame start (position 0,0)
- `cost_grad`  output  12  unsigned gradient magnitude, to normaliser `cost_grad`
- `grad_valid`  output  1  `cost_grad` carries a sample
- `grad_sof`  output  1  sample corresponds to the frame's first input pixel

## Operation
- Position counters x (0..IMG_W-1) and y (0..IMG_H-1) give the coordinate of each accepted pixel.
  - An accepted pixel with `pix_sof`=1 is (0,0).
  - After each accept: x wraps from IMG_W-1 to 0 and increments y; y wraps from IMG_H-1 to 0 (implicit next frame).
- Line buffers: two IMG_W×8 arrays, LB0 = row y-1 and LB1 = row y-2, read combinationally at address x. On accept: LB1[x]<=LB0[x], LB0[x]<=pix_in.
- Window: 3×3 register array. On accept, shift left one column and load the new right column {LB1[x], LB0[x], pix_in} (top to bottom).
  - Window element p[r][c] has r=0 as the top row and c=0 as the left column; the window centre is pixel (x-1, y-1).
- Stage 2 (registered):
  - Gx = (p02+2p12+p22) − (p00+2p10+p20)
  - Gy = (p20+2p21+p22) − (p00+2p01+p02)
  - Both are signed 11-bit, range ±1020.
- Stage 3 (registered): sum = |Gx|+|Gy|, 11-bit unsigned, max 2040, zero-extended to 12 bits.
- Border: if the accept had x<2 or y<2 (window not fully in frame), the sample is forced to 0. The flag is pipelined alongside the data.
- Output stream: exactly one sample per accepted pixel, IMG_W×IMG_H samples per frame, same order as the input. The sample for input (x,y) is the gradient of centre (x-1,y-1), or 0 on the border.
- `pix_sof` mid-frame: counters restart at (0,0) on that pixel. Stale line-buffer contents need no clearing, because rows 0–1 are border-forced.
- `pix_sof` on a non-accepted cycle is ignored.

## Timing
- Pipeline advances on every `clken`=1 edge, whether or not `pix_valid` is high. Cycles with `pix_valid`=0 insert bubbles: valid=0 and sof=0 propagate.
- Latency: a pixel accepted at clken edge N produces `grad_valid`=1 after clken edge N+2. With `clken` held high this is 3 rising edges including the accept edge.
- Throughput: 1 sample per clken cycle, no backpressure.
- `clken`=0: outputs and all internal state frozen. `grad_valid` keeps its last value, so the consumer must also gate on `clken`.
- Reset (`rst`=0 at a rising edge):
  - x, y, window, stage registers and validity flags are cleared; `cost_grad`=0, `grad_valid`=0, `grad_sof`=0.
  - Line-buffer contents are don't-care.
  - Reset overrides `clken`.
  - Reset mid-frame discards in-flight samples; the next accepted pixel is (0,0) regardless of `pix_sof`.
- Simultaneous `pix_sof` and x/y wrap: `pix_sof` wins.

## Configuration
- `SOBEL_GRAD_CLIP_EN`
  - Defined: stage 3 saturates the sum to 12'd255, so the normaliser's input never exceeds 255.
  - Undefined: full 0..2040 range passes through, zero-extended.
  - Latency is identical in both builds.

## Test plan
All scenarios use IMG_W=8, IMG_H=4.
- Flat frame, all pixels 77, `clken`=1 continuously -> 32 samples, all `cost_grad`=0; `grad_sof`=1 only on the first; first `grad_valid` 2 cycles after the first accept.
- Vertical step: columns 0–3 = 0, columns 4–7 = 100 -> for y≥2, inputs x=4 and x=5 give 400; all other samples 0. With `SOBEL_GRAD_CLIP_EN` those samples are 255.
- Horizontal step: rows 0–1 = 0, rows 2–3 = 50 -> inputs at y=2 and y=3 with x≥2 give 200; all other samples 0.
- Stalls and bubbles: vertical-step frame with `clken` low 3 cycles every 5, plus random `pix_valid` gaps -> same 32-sample sequence as the unstalled run; outputs constant while `clken`=0.
- `pix_sof` asserted at input (5,2) mid-frame, followed by a full flat-0 frame -> counters restart and 32 zero samples follow, with `grad_sof` on the first.
- `rst` low for one cycle mid-frame with `clken`=0 -> next edge outputs 0/0/0; the next accepted pixel without `pix_sof` is treated as (0,0).

Source files
------------

// File: rtl/sobel_grad.sv
// Streaming 3x3 Sobel L1 gradient magnitude with two internal line buffers.
// Build option: define SOBEL_GRAD_CLIP_EN to saturate the output at 255.
module sobel_grad #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clken,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    input  logic        pix_sof,
    output logic [11:0] cost_grad,
    output logic        grad_valid,
    output logic        grad_sof
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    logic [XW-1:0] x_q;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] y_q;
    logic [YW-1:0] cur_y;
    logic          accept;
    logic          x_last;
    logic          y_last;

    logic [7:0] lb0 [IMG_W];
    logic [7:0] lb1 [IMG_W];
    logic [7:0] lb0_rd;
    logic [7:0] lb1_rd;

    logic [7:0] win [3][3];
    logic       v1, s1, b1;

    logic [9:0]         gx_pos, gx_neg;
    logic [9:0]         gy_pos, gy_neg;
    logic signed [10:0] gx_d, gy_d;
    logic signed [10:0] gx_q, gy_q;
    logic               v2, s2, b2;

    logic [10:0] gx_abs, gy_abs;
    logic [10:0] sum;
    logic [11:0] grad_val;

    assign accept = clken & pix_valid;
    assign cur_x  = pix_sof ? '0 : x_q;
    assign cur_y  = pix_sof ? '0 : y_q;
    assign x_last = (cur_x == XW'(IMG_W - 1));
    assign y_last = (cur_y == YW'(IMG_H - 1));
    assign lb0_rd = lb0[cur_x];
    assign lb1_rd = lb1[cur_x];

    // Raster position of the next pixel; sof forces the current one to (0,0).
    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (accept) begin
            if (x_last) begin
                x_q <= '0;
                y_q <= y_last ? '0 : cur_y + YW'(1);
            end else begin
                x_q <= cur_x + XW'(1);
                y_q <= cur_y;
            end
        end
    end

    // Line buffers: lb0 holds the previous row, lb1 the row before it.
    always_ff @(posedge clk) begin
        if (rst && accept) begin
            lb1[cur_x] <= lb0_rd;
            lb0[cur_x] <= pix_in;
        end
    end

    // 3x3 window: shift left, load new right column top to bottom.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1_rd;
            win[1][2] <= lb0_rd;
            win[2][2] <= pix_in;
        end
    end

    // Stage-1 side flags travel with the window contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v1 <= 1'b0;
            s1 <= 1'b0;
            b1 <= 1'b0;
        end else if (clken) begin
            v1 <= accept;
            s1 <= accept && (cur_x == '0) && (cur_y == '0);
            b1 <= (cur_x < XW'(2)) || (cur_y < YW'(2));
        end
    end

    // Sobel kernels as positive and negative weighted sums.
    always_comb begin
        gx_pos = {2'b0, win[0][2]} + {1'b0, win[1][2], 1'b0}
               + {2'b0, win[2][2]};
        gx_neg = {2'b0, win[0][0]} + {1'b0, win[1][0], 1'b0}
               + {2'b0, win[2][0]};
        gy_pos = {2'b0, win[2][0]} + {1'b0, win[2][1], 1'b0}
               + {2'b0, win[2][2]};
        gy_neg = {2'b0, win[0][0]} + {1'b0, win[0][1], 1'b0}
               + {2'b0, win[0][2]};
        gx_d   = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
        gy_d   = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
    end

    // Stage 2: signed gradients.
    always_ff @(posedge clk) begin
        if (!rst) begin
            gx_q <= '0;
            gy_q <= '0;
            v2   <= 1'b0;
            s2   <= 1'b0;
            b2   <= 1'b0;
        end else if (clken) begin
            gx_q <= gx_d;
            gy_q <= gy_d;
            v2   <= v1;
            s2   <= s1;
            b2   <= b1;
        end
    end

    // L1 magnitude, optional saturation for the normaliser.
    always_comb begin
        gx_abs = gx_q[10] ? 11'(-gx_q) : 11'(gx_q);
        gy_abs = gy_q[10] ? 11'(-gy_q) : 11'(gy_q);
        sum    = gx_abs + gy_abs;
`ifdef SOBEL_GRAD_CLIP_EN
        grad_val = (sum > 11'd255) ? 12'd255 : {1'b0, sum};
`else
        grad_val = {1'b0, sum};
`endif
    end

    // Stage 3: output register, border samples forced to zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cost_grad  <= '0;
            grad_valid <= 1'b0;
            grad_sof   <= 1'b0;
        end else if (clken) begin
            cost_grad  <= b2 ? 12'd0 : grad_val;
            grad_valid <= v2;
            grad_sof   <= s2;
        end
    end

endmodule

// File: tb/tb_sobel_grad.sv
// Random and directed stimulus for sobel_grad on an 8x4 image,
// checked against a kernel-convolution model of the image.
module tb_sobel_grad;

    localparam int W = 8;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clken = 1'b0;
    logic [7:0]  pix_in = '0;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic [11:0] cost_grad;
    logic        grad_valid;
    logic        grad_sof;

    sobel_grad #(.IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .clken     (clken),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .cost_grad (cost_grad),
        .grad_valid(grad_valid),
        .grad_sof  (grad_sof)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int val;
        bit sof;
    } exp_t;

    int   total = 0;
    int   bad = 0;
    exp_t q[$];
    int   got[$];
    bit   gsof[$];
    int   vref[$];
    int   img[H][W];
    int   mx = 0;
    int   my = 0;
    int   cecnt = 0;
    bit   started = 0;
    bit   edge_ce = 0;
    bit   edge_rst = 0;
    logic [11:0] p_cost;
    logic        p_valid;
    logic        p_sof;

    localparam int KX[3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    localparam int KY[3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

    function automatic void chk(string name, int a, int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, a, e, $time);
        end
    endfunction

    function automatic int grad_of(input int w[3][3]);
        int gx = 0;
        int gy = 0;
        int s;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                gx += KX[r][c] * w[r][c];
                gy += KY[r][c] * w[r][c];
            end
        end
        s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_GRAD_CLIP_EN
        if (s > 255) s = 255;
`endif
        return s;
    endfunction

    function automatic int model_px(int px, int py);
        int w[3][3];
        if (px < 2 || py < 2) return 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w[r][c] = img[py - 2 + r][px - 2 + c];
            end
        end
        return grad_of(w);
    endfunction

    task automatic cyc(input bit ce, input bit v, input int p,
                       input bit s, input bit r = 1'b1);
        exp_t e;
        @(negedge clk);
        clken = ce;
        pix_valid = v;
        pix_in = 8'(p);
        pix_sof = s;
        rst = r;
        @(posedge clk);
        started = 1'b1;
        edge_ce = ce;
        edge_rst = !r;
        if (!r) begin
            mx = 0;
            my = 0;
            q.delete();
        end else if (ce) begin
            cecnt++;
            if (v) begin
                if (s) begin
                    mx = 0;
                    my = 0;
                end
                img[my][mx] = p & 255;
                e.due = cecnt + 2;
                e.val = model_px(mx, my);
                e.sof = (mx == 0 && my == 0);
                q.push_back(e);
                mx++;
                if (mx == W) begin
                    mx = 0;
                    my = (my + 1) % H;
                end
            end
        end
    endtask

    // Compare process: outputs sampled half a cycle after each edge.
    always @(negedge clk) begin
        bit ev;
        if (started) begin
            if (edge_rst) begin
                chk("rst_cost", int'(cost_grad), 0);
                chk("rst_valid", int'(grad_valid), 0);
                chk("rst_sof", int'(grad_sof), 0);
            end else if (edge_ce) begin
                ev = q.size() > 0 && q[0].due == cecnt;
                chk("valid", int'(grad_valid), int'(ev));
                if (ev) begin
                    chk("cost", int'(cost_grad), q[0].val);
                    chk("sof", int'(grad_sof), int'(q[0].sof));
                    got.push_back(int'(cost_grad));
                    gsof.push_back(grad_sof);
                    void'(q.pop_front());
                end else begin
                    chk("bubble_sof", int'(grad_sof), 0);
                end
            end else begin
                chk("hold_cost", int'(cost_grad), int'(p_cost));
                chk("hold_valid", int'(grad_valid), int'(p_valid));
                chk("hold_sof", int'(grad_sof), int'(p_sof));
            end
        end
        p_cost = cost_grad;
        p_valid = grad_valid;
        p_sof = grad_sof;
    end

    function automatic int pix_of(int kind, int x, int y);
        case (kind)
            0: return 77;
            1: return (x >= 4) ? 100 : 0;
            2: return (y >= 2) ? 50 : 0;
            3: return int'($urandom_range(0, 255));
            default: return 0;
        endcase
    endfunction

    task automatic frame(input int kind, input bit sof0);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                cyc(1'b1, 1'b1, pix_of(kind, x, y),
                    sof0 && x == 0 && y == 0);
            end
        end
    endtask

    task automatic flush();
        repeat (4) cyc(1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic clear_got();
        got.delete();
        gsof.delete();
    endtask

    int w[3][3];
    int k;
    int n;
    int clip400;
    int zeros;

    initial begin
`ifdef SOBEL_GRAD_CLIP_EN
        clip400 = 255;
`else
        clip400 = 400;
`endif
        // pin the model on hand-computed windows
        w = '{'{0, 0, 100}, '{0, 0, 100}, '{0, 0, 100}};
        chk("pin_vstep", grad_of(w), clip400);
        w = '{'{0, 0, 0}, '{0, 0, 0}, '{50, 50, 50}};
        chk("pin_hstep", grad_of(w), 200);
        w = '{'{255, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
`ifdef SOBEL_GRAD_CLIP_EN
        chk("pin_corner", grad_of(w), 255);
`else
        chk("pin_corner", grad_of(w), 510);
`endif

        cyc(1'b1, 1'b0, 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b0);

        // flat frame
        clear_got();
        frame(0, 1'b1);
        flush();
        chk("flat_count", got.size(), 32);
        zeros = 0;
        foreach (got[i]) if (got[i] == 0) zeros++;
        chk("flat_zeros", zeros, 32);
        chk("flat_sof0", int'(gsof[0]), 1);
        chk("flat_sof1", int'(gsof[1]), 0);

        // vertical step
        clear_got();
        frame(1, 1'b1);
        flush();
        chk("v_x4y2", got[20], clip400);
        chk("v_x5y2", got[21], clip400);
        chk("v_x4y3", got[28], clip400);
        chk("v_x3y2", got[19], 0);
        chk("v_x6y3", got[30], 0);
        vref = got;

        // horizontal step
        clear_got();
        frame(2, 1'b1);
        flush();
        chk("h_x2y2", got[18], 200);
        chk("h_x7y3", got[31], 200);
        chk("h_x1y2", got[17], 0);

        // vertical step with stalls and bubbles
        clear_got();
        n = 0;
        k = 0;
        while (n < 32) begin
            bit ce;
            bit v;
            ce = (k % 5) >= 3;
            v = $urandom_range(0, 3) != 0;
            cyc(ce, v, pix_of(1, n % W, n / W), n == 0);
            if (ce && v) n++;
            k++;
        end
        flush();
        chk("stall_count", got.size(), 32);
        for (int i = 0; i < 32 && i < got.size(); i++) begin
            chk("stall_seq", got[i], vref[i]);
        end

        // random frames, random clken and bubbles
        for (int f = 0; f < 3; f++) begin
            n = 0;
            while (n < 32) begin
                bit ce;
                bit v;
                ce = $urandom_range(0, 3) != 0;
                v = $urandom_range(0, 2) != 0;
                cyc(ce, v, int'($urandom_range(0, 255)),
                    n == 0 && f == 0);
                if (ce && v) n++;
            end
        end
        flush();

        // sof mid-frame at (5,2) followed by a flat-0 frame
        clear_got();
        for (int i = 0; i < 21; i++) begin
            cyc(1'b1, 1'b1, pix_of(1, i % W, i / W), i == 0);
        end
        frame(4, 1'b1);
        flush();
        chk("msof_count", got.size(), 53);
        zeros = 0;
        for (int i = 21; i < got.size(); i++) if (got[i] == 0) zeros++;
        chk("msof_zeros", zeros, 32);
        chk("msof_sof", int'(gsof[21]), 1);

        // reset mid-frame with clken low, then frame without sof
        for (int i = 0; i < 13; i++) begin
            cyc(1'b1, 1'b1, int'($urandom_range(0, 255)), i == 0);
        end
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
        clear_got();
        frame(1, 1'b0);
        flush();
        chk("rst_count", got.size(), 32);
        chk("rst_first_sof", int'(gsof[0]), 1);
        chk("rst_x4y2", got[20], clip400);
        chk("drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
